// File: rtl/hart_test_monitor_pkg.sv
// Shared encodings and default address/PC map for the multi-hart run monitor.
package hart_test_monitor_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   localparam logic        RW_WRITE               = 1'b1;
   localparam int unsigned RESULT_PASS            = 1;
   localparam int unsigned DEF_RESULT_ADDR_BASE   = 2560;
   localparam int unsigned DEF_RESULT_ADDR_STRIDE = 3072;
   localparam int unsigned DEF_END_PC_BASE        = 512;
   localparam int unsigned DEF_END_PC_STRIDE      = 256;

endpackage

// File: rtl/hart_tm_slot.sv
// Per-hart flags: sticky stopped, pass (overridable by fail) and sticky fail.
module hart_tm_slot
   import hart_test_monitor_pkg::*;
#(
   parameter int unsigned       HART_IDX    = 0,
   parameter int unsigned       HART_ID_W   = 2,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [DATA_W-1:0] RESULT_ADDR = '0,
   parameter logic [DATA_W-1:0] END_PC      = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 if_valid,
   input  logic [DATA_W-1:0]    if_pc,
   input  logic [HART_ID_W-1:0] if_hart_id,
   input  logic [DATA_W-1:0]    mem_spm_addr,
   input  logic                 mem_spm_rw,
   input  logic [DATA_W-1:0]    mem_spm_wr_data,
   output logic                 stopped,
   output logic                 pass,
   output logic                 fail
);

   logic wr_hit_c;
   logic stop_hit_c;

   always_comb begin
      wr_hit_c   = (mem_spm_rw == RW_WRITE) && (mem_spm_addr == RESULT_ADDR);
      stop_hit_c = if_valid && (if_hart_id == HART_ID_W'(HART_IDX)) && (if_pc == END_PC);
   end

   // Result write and stop hit are independent; both apply in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stopped <= 1'b0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else if (enable) begin
         if (wr_hit_c) begin
            if (mem_spm_wr_data == DATA_W'(RESULT_PASS)) begin
               if (!fail) pass <= 1'b1;
            end else begin
               fail <= 1'b1;
               pass <= 1'b0;
            end
         end
         if (stop_hit_c) stopped <= 1'b1;
      end
   end

endmodule

// File: rtl/hart_test_monitor.sv
// Run monitor: per-hart result/stop slots, RUN cycle counter and sticky verdict.
module hart_test_monitor
   import hart_test_monitor_pkg::*;
#(
   parameter int unsigned HART_NUM           = 4,
   parameter int unsigned HART_ID_W          = 2,
   parameter int unsigned DATA_W             = 32,
   parameter int unsigned RESULT_ADDR_BASE   = DEF_RESULT_ADDR_BASE,
   parameter int unsigned RESULT_ADDR_STRIDE = DEF_RESULT_ADDR_STRIDE,
   parameter int unsigned END_PC_BASE        = DEF_END_PC_BASE,
   parameter int unsigned END_PC_STRIDE      = DEF_END_PC_STRIDE,
   parameter int unsigned STOP_COUNT         = 1,
   parameter int unsigned MAX_CYCLES         = 4000,
   parameter int unsigned CNT_W              = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [DATA_W-1:0]    if_pc,
   input  logic [HART_ID_W-1:0] if_hart_id,
   input  logic [DATA_W-1:0]    mem_spm_addr,
   input  logic                 mem_spm_rw,
   input  logic [DATA_W-1:0]    mem_spm_wr_data,
   output logic [HART_NUM-1:0]  hart_stopped,
   output logic [HART_NUM-1:0]  hart_pass,
   output logic [HART_NUM-1:0]  hart_fail,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout
);

   localparam int unsigned POP_W = $clog2(HART_NUM + 1);

   state_t           state;
   logic [POP_W-1:0] stop_pop_c;
   logic             stop_done_c;
   logic             time_up_c;
   logic             finish_c;
   logic             enable_c;

   // Flags freeze on the finishing edge so the verdict matches the flags shown.
   always_comb begin
      stop_pop_c = '0;
      for (int i = 0; i < HART_NUM; i++) begin
         stop_pop_c = stop_pop_c + POP_W'(hart_stopped[i]);
      end
      stop_done_c = (stop_pop_c >= POP_W'(STOP_COUNT));
      time_up_c   = (cycle_count == CNT_W'(MAX_CYCLES - 1));
      finish_c    = (state == ST_RUN) && (stop_done_c || time_up_c);
      enable_c    = (state == ST_RUN) && !finish_c;
   end

   for (genvar h = 0; h < HART_NUM; h++) begin : g_slot
      hart_tm_slot #(
         .HART_IDX    (h),
         .HART_ID_W   (HART_ID_W),
         .DATA_W      (DATA_W),
         .RESULT_ADDR (DATA_W'(RESULT_ADDR_BASE + h * RESULT_ADDR_STRIDE)),
         .END_PC      (DATA_W'(END_PC_BASE + h * END_PC_STRIDE))
      ) u_slot (
         .clk             (clk),
         .reset           (reset),
         .enable          (enable_c),
         .if_valid        (if_valid),
         .if_pc           (if_pc),
         .if_hart_id      (if_hart_id),
         .mem_spm_addr    (mem_spm_addr),
         .mem_spm_rw      (mem_spm_rw),
         .mem_spm_wr_data (mem_spm_wr_data),
         .stopped         (hart_stopped[h]),
         .pass            (hart_pass[h]),
         .fail            (hart_fail[h])
      );
   end

   // Completion takes precedence over a coincident timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         cycle_count <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (finish_c) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  timeout <= !stop_done_c;
                  pass    <= stop_done_c && !(|hart_fail);
                  fail    <= !stop_done_c || (|hart_fail);
               end else if (cycle_count != '1) begin
                  cycle_count <= cycle_count + CNT_W'(1);
               end
            end
            ST_DONE: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hart_test_monitor.sv
// Directed scoreboard bench for hart_test_monitor: default and short-timeout instances.
module tb_hart_test_monitor;
   import hart_test_monitor_pkg::*;

   logic        clk = 1'b0;
   logic        reset_a, reset_b;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [1:0]  if_hart_id;
   logic [31:0] mem_spm_addr;
   logic        mem_spm_rw;
   logic [31:0] mem_spm_wr_data;

   logic [3:0]  a_stopped, a_hpass, a_hfail, b_stopped, b_hpass, b_hfail;
   logic [31:0] a_count, b_count;
   logic        a_done, a_pass, a_fail, a_timeout, b_done, b_pass, b_fail, b_timeout;

   always #5 clk = ~clk;

   hart_test_monitor u_dut_a (
      .clk(clk), .reset(reset_a), .if_valid(if_valid), .if_pc(if_pc), .if_hart_id(if_hart_id),
      .mem_spm_addr(mem_spm_addr), .mem_spm_rw(mem_spm_rw), .mem_spm_wr_data(mem_spm_wr_data),
      .hart_stopped(a_stopped), .hart_pass(a_hpass), .hart_fail(a_hfail), .cycle_count(a_count),
      .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout));

   hart_test_monitor #(.STOP_COUNT(2), .MAX_CYCLES(20)) u_dut_b (
      .clk(clk), .reset(reset_b), .if_valid(if_valid), .if_pc(if_pc), .if_hart_id(if_hart_id),
      .mem_spm_addr(mem_spm_addr), .mem_spm_rw(mem_spm_rw), .mem_spm_wr_data(mem_spm_wr_data),
      .hart_stopped(b_stopped), .hart_pass(b_hpass), .hart_fail(b_hfail), .cycle_count(b_count),
      .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout));

   typedef struct {
      string       tag;
      logic [3:0]  stopped, hpass, hfail;
      logic        done, pass, fail, timeout;
      logic [31:0] count;
   } snap_t;

   snap_t sb[$];
   int    checks = 0;
   int    errors = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [3:0] st, input logic [3:0] hp,
                               input logic [3:0] hf, input logic d, input logic p, input logic f,
                               input logic t, input logic [31:0] c);
      snap_t s;
      s.tag = tag; s.stopped = st; s.hpass = hp; s.hfail = hf;
      s.done = d; s.pass = p; s.fail = f; s.timeout = t; s.count = c;
      sb.push_back(s);
   endtask

   function automatic snap_t observe(input bit use_b);
      snap_t o;
      o.tag = "";
      if (use_b) begin
         o.stopped = b_stopped; o.hpass = b_hpass; o.hfail = b_hfail; o.done = b_done;
         o.pass = b_pass; o.fail = b_fail; o.timeout = b_timeout; o.count = b_count;
      end else begin
         o.stopped = a_stopped; o.hpass = a_hpass; o.hfail = a_hfail; o.done = a_done;
         o.pass = a_pass; o.fail = a_fail; o.timeout = a_timeout; o.count = a_count;
      end
      return o;
   endfunction

   task automatic check_dut(input bit use_b);
      snap_t e, o;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      o = observe(use_b);
      cmp({e.tag, ".hart_stopped"}, 32'(o.stopped), 32'(e.stopped));
      cmp({e.tag, ".hart_pass"},    32'(o.hpass),   32'(e.hpass));
      cmp({e.tag, ".hart_fail"},    32'(o.hfail),   32'(e.hfail));
      cmp({e.tag, ".done"},         32'(o.done),    32'(e.done));
      cmp({e.tag, ".pass"},         32'(o.pass),    32'(e.pass));
      cmp({e.tag, ".fail"},         32'(o.fail),    32'(e.fail));
      cmp({e.tag, ".timeout"},      32'(o.timeout), 32'(e.timeout));
      cmp({e.tag, ".cycle_count"},  o.count,        e.count);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      if_valid = 1'b0; if_pc = '0; if_hart_id = '0;
      mem_spm_rw = ~RW_WRITE; mem_spm_addr = '0; mem_spm_wr_data = '0;
   endtask

   task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
      mem_spm_rw = RW_WRITE; mem_spm_addr = addr; mem_spm_wr_data = data;
   endtask

   task automatic drive_fetch(input logic [1:0] hart, input logic [31:0] pc);
      if_valid = 1'b1; if_hart_id = hart; if_pc = pc;
   endtask

   task automatic do_reset(input bit use_b, input string tag);
      idle();
      if (use_b) reset_b = 1'b1; else reset_a = 1'b1;
      step();
      if (use_b) reset_b = 1'b0; else reset_a = 1'b0;
      expect_state(tag, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      check_dut(use_b);
   endtask

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      idle();
      step();

      // Hart 1 passes and stops: verdict pass, counter frozen.
      do_reset(0, "t1_reset");
      drive_write(32'd5632, 32'd1);
      expect_state("t1_write", 4'b0000, 4'b0010, 4'b0000, 0, 0, 0, 0, 1);
      step(); check_dut(0);
      idle(); drive_fetch(2'd1, 32'd768);
      expect_state("t1_fetch", 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 0, 2);
      step(); check_dut(0);
      idle();
      expect_state("t1_done", 4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 0, 2);
      step(); check_dut(0);
      step(); step();
      expect_state("t1_frozen", 4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 0, 2);
      step(); check_dut(0);

      // Fail word then pass word on hart 0: fail sticks.
      do_reset(0, "t2_reset");
      drive_write(32'd2560, 32'd7);
      expect_state("t2_bad", 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 0, 1);
      step(); check_dut(0);
      drive_write(32'd2560, 32'd1);
      expect_state("t2_good", 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 0, 2);
      step(); check_dut(0);
      idle(); drive_fetch(2'd0, 32'd512);
      expect_state("t2_fetch", 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0, 3);
      step(); check_dut(0);
      idle();
      expect_state("t2_done", 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 0, 3);
      step(); check_dut(0);

      // Ignored traffic, then a same-cycle result write and stop hit, then DONE freeze.
      do_reset(0, "t3_reset");
      mem_spm_rw = ~RW_WRITE; mem_spm_addr = 32'd2560; mem_spm_wr_data = 32'd7;
      expect_state("t3_read", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
      step(); check_dut(0);
      idle(); if_valid = 1'b0; if_pc = 32'd512; if_hart_id = 2'd0;
      expect_state("t3_invalid", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 2);
      step(); check_dut(0);
      idle(); drive_fetch(2'd2, 32'd768);
      expect_state("t3_wrong_hart", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3);
      step(); check_dut(0);
      idle(); drive_write(32'd2561, 32'd5);
      expect_state("t3_bad_addr", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 4);
      step(); check_dut(0);
      idle(); drive_write(32'd8704, 32'd1); drive_fetch(2'd3, 32'd1280);
      expect_state("t3_both", 4'b1000, 4'b0100, 4'b0000, 0, 0, 0, 0, 5);
      step(); check_dut(0);
      idle(); drive_write(32'd2560, 32'd9); drive_fetch(2'd0, 32'd512);
      expect_state("t3_done", 4'b1000, 4'b0100, 4'b0000, 1, 1, 0, 0, 5);
      step(); check_dut(0);
      expect_state("t3_ignored", 4'b1000, 4'b0100, 4'b0000, 1, 1, 0, 0, 5);
      step(); check_dut(0);
      idle();

      // Two distinct stops needed; repeated hits on one hart count once.
      reset_a = 1'b1;
      do_reset(1, "t4_reset");
      drive_fetch(2'd2, 32'd1024);
      for (int i = 1; i <= 3; i++) begin
         expect_state("t4_repeat", 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'(i));
         step(); check_dut(1);
      end
      idle();
      expect_state("t4_gap", 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 4);
      step(); check_dut(1);
      drive_fetch(2'd3, 32'd1280);
      expect_state("t4_second", 4'b1100, 4'b0000, 4'b0000, 0, 0, 0, 0, 5);
      step(); check_dut(1);
      idle();
      expect_state("t4_done", 4'b1100, 4'b0000, 4'b0000, 1, 1, 0, 0, 5);
      step(); check_dut(1);

      // Timeout after 20 RUN cycles with cycle_count held at 19.
      do_reset(1, "t5_reset");
      for (int i = 1; i <= 19; i++) begin
         expect_state("t5_count", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'(i));
         step(); check_dut(1);
      end
      expect_state("t5_timeout", 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 1, 19);
      step(); check_dut(1);
      step();
      expect_state("t5_hold", 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 1, 19);
      step(); check_dut(1);

      // Completion lands on the timeout cycle: pass wins.
      do_reset(1, "t6_reset");
      for (int i = 0; i < 17; i++) step();
      drive_fetch(2'd0, 32'd512);
      expect_state("t6_stop0", 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 18);
      step(); check_dut(1);
      drive_fetch(2'd1, 32'd768);
      expect_state("t6_stop1", 4'b0011, 4'b0000, 4'b0000, 0, 0, 0, 0, 19);
      step(); check_dut(1);
      idle();
      expect_state("t6_race", 4'b0011, 4'b0000, 4'b0000, 1, 1, 0, 0, 19);
      step(); check_dut(1);

      // Asynchronous mid-run reset with flags set.
      reset_b = 1'b1;
      do_reset(0, "t7_reset");
      drive_write(32'd2560, 32'd1);
      expect_state("t7_pass0", 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 1);
      step(); check_dut(0);
      drive_write(32'd5632, 32'd9);
      expect_state("t7_fail1", 4'b0000, 4'b0001, 4'b0010, 0, 0, 0, 0, 2);
      step(); check_dut(0);
      idle();
      step();
      #2 reset_a = 1'b1;
      expect_state("t7_async", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      #1 check_dut(0);
      @(negedge clk);
      reset_a = 1'b0;
      expect_state("t7_release", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      check_dut(0);
      expect_state("t7_restart", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
      step(); check_dut(0);

      cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
